// File: rtl/mc68681_pkg.sv
// mc68681_pkg
// Shared definitions for the MC68681 DUART core slice.
//   iack_state_t      : interrupt-acknowledge responder state encoding
//                       (2'd3 is unused and decodes back to IDLE)
//   IVR_RESET_DEFAULT : IVR contents after reset (the "uninitialised" vector)
//   IVR_OFFSET        : register offset of the IVR, for the top-level decoder
package mc68681_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRIVE = 2'd2
   } iack_state_t;

   localparam logic [7:0] IVR_RESET_DEFAULT = 8'h0F;
   localparam logic [3:0] IVR_OFFSET        = 4'hC;

endpackage

// File: rtl/iack_ivr_responder_if.sv
// iack_ivr_responder_if
// Register-access and interrupt-acknowledge handshake signals of the IVR responder.
//   cs, rw, data : IVR register select, read/write strobe (1 = read), write data
//   INT          : active-low interrupt request from the ISR/IMR block
//   IACK         : active-low interrupt acknowledge from the CPU (asynchronous)
//   DTACK        : active-low data-transfer acknowledge returned for the IACK cycle
// master = CPU / interrupt-source side, slave = the responder.
interface iack_ivr_responder_if;

   logic       cs;
   logic       rw;
   logic [7:0] data;
   logic       INT;
   logic       IACK;
   logic       DTACK;

   modport master (output cs, rw, data, INT, IACK, input DTACK);
   modport slave  (input cs, rw, data, INT, IACK, output DTACK);

endinterface

// File: rtl/sync_ff.sv
// sync_ff
// Parameterised-depth flop chain for bringing asynchronous inputs into the clk
// domain. Every stage resets to 1, which is the inactive level of the
// active-low pins it is used on (IACK, CTS, IP).
//   clk, reset : clock and asynchronous active-high reset
//   d          : asynchronous input
//   q          : synchronised output, STAGES clk edges behind d
module sync_ff #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   // Shift chain; stage 0 is the only flop that may go metastable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '1;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/iack_ivr_responder.sv
// iack_ivr_responder
// Holds the Interrupt Vector Register and answers CPU interrupt-acknowledge
// cycles while the DUART interrupt request is pending.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : register access + INT/IACK/DTACK handshake (slave side)
//   data_out   : IVR read data or latched vector; high impedance when idle.
//                Kept as a plain port because it is the tri-stated data bus.
// Parameters:
//   SYNC_STAGES : depth of the IACK synchroniser (>= 2)
//   DTACK_DELAY : clk cycles spent in WAIT before DRIVE (0..15)
//   IVR_RESET   : IVR value after reset
module iack_ivr_responder
   import mc68681_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter int         DTACK_DELAY = 1,
   parameter logic [7:0] IVR_RESET   = IVR_RESET_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   iack_ivr_responder_if.slave  bus,
   output wire  [7:0]           data_out
);

   localparam logic [3:0] DELAY_LOAD = 4'(DTACK_DELAY);

   logic        iack_s;
   logic [7:0]  ivr;
   logic [7:0]  vec;
   logic [3:0]  cnt;
   logic        dtack_q;
   iack_state_t state;

   sync_ff #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (1)
   ) u_iack_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.IACK),
      .q     (iack_s)
   );

   // IVR register. Writes are accepted in every state; the vector actually
   // presented on the bus comes from vec, so a write mid-cycle only takes
   // effect from the next acknowledge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ivr <= IVR_RESET;
      end else if (bus.cs && !bus.rw) begin
         ivr <= bus.data;
      end
   end

   // Acknowledge sequencer. The vector is latched from the pre-edge IVR on
   // leaving IDLE. The counter is loaded with DTACK_DELAY and DRIVE is entered
   // when it reads 1, so it never has to wrap. DTACK is registered so it
   // changes on the same edge as the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         vec     <= IVR_RESET;
         dtack_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (!iack_s && !bus.INT) begin
                  vec <= ivr;
                  if (DELAY_LOAD == 4'd0) begin
                     state   <= DRIVE;
                     cnt     <= 4'd0;
                     dtack_q <= 1'b0;
                  end else begin
                     state <= WAIT;
                     cnt   <= DELAY_LOAD;
                  end
               end
            end
            WAIT: begin
               // Aborted acknowledge or interrupt withdrawn: back off silently.
               if (iack_s || bus.INT) begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end else if (cnt == 4'd1) begin
                  state   <= DRIVE;
                  cnt     <= 4'd0;
                  dtack_q <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DRIVE: begin
               // INT is deliberately ignored here; only IACK ends the cycle.
               if (iack_s) begin
                  state   <= IDLE;
                  dtack_q <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= 4'd0;
               dtack_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.DTACK = dtack_q;

   // The vector has priority over register reads while DRIVE holds the bus.
   assign data_out = (state == DRIVE)       ? vec :
                     (bus.cs && bus.rw)     ? ivr :
                                              8'bz;

endmodule

// File: tb/tb_iack_ivr_responder.sv
// tb_iack_ivr_responder
// Directed bench for iack_ivr_responder. u_dut uses the default parameters;
// u_dut3 uses DTACK_DELAY=3 for the interrupt-withdrawn-in-WAIT case.
// Inputs change 1 ns after a rising edge and outputs are sampled 1 ns after
// that, so nothing is sampled on an active edge.
module tb_iack_ivr_responder;

   logic       clk;
   logic       reset;
   wire  [7:0] data_out;
   wire  [7:0] data_out3;

   int pass_count  = 0;
   int check_count = 0;

   iack_ivr_responder_if bus ();
   iack_ivr_responder_if bus3 ();

   iack_ivr_responder u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .data_out (data_out)
   );

   iack_ivr_responder #(
      .SYNC_STAGES (2),
      .DTACK_DELAY (3),
      .IVR_RESET   (8'h0F)
   ) u_dut3 (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus3),
      .data_out (data_out3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive the register-access inputs of the default instance.
   task automatic applyStimulus(input logic cs, input logic rw, input logic [7:0] data);
      bus.cs   = cs;
      bus.rw   = rw;
      bus.data = data;
      #1;
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] isZ(input logic z);
      return {7'd0, z};
   endfunction

   logic dtack_dropped;
   logic dout_driven;

   initial begin
      reset     = 1'b1;
      bus.cs    = 1'b0;
      bus.rw    = 1'b1;
      bus.data  = 8'h00;
      bus.INT   = 1'b1;
      bus.IACK  = 1'b1;
      bus3.cs   = 1'b0;
      bus3.rw   = 1'b1;
      bus3.data = 8'h00;
      bus3.INT  = 1'b1;
      bus3.IACK = 1'b1;

      // Reset state
      #12;
      checkOutput("reset_dtack", {7'd0, bus.DTACK}, 8'h01);
      checkOutput("reset_dout_z", isZ(data_out === 8'bz), 8'h01);
      @(negedge clk);
      reset = 1'b0;
      waitEdges(1);
      applyStimulus(1'b1, 1'b1, 8'h00);
      checkOutput("reset_ivr_read", data_out, 8'h0F);

      // IVR write then read back; deselected bus floats
      applyStimulus(1'b1, 1'b0, 8'h40);
      waitEdges(1);
      applyStimulus(1'b1, 1'b1, 8'h00);
      checkOutput("ivr_read_40", data_out, 8'h40);
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("deselect_z", isZ(data_out === 8'bz), 8'h01);

      // Basic acknowledge: IACK falls before E1, DTACK at E4
      bus.INT  = 1'b0;
      bus.IACK = 1'b0;
      waitEdges(3);
      checkOutput("ack_dtack_e3", {7'd0, bus.DTACK}, 8'h01);
      waitEdges(1);
      checkOutput("ack_dtack_e4", {7'd0, bus.DTACK}, 8'h00);
      checkOutput("ack_vector", data_out, 8'h40);
      bus.IACK = 1'b1;
      waitEdges(2);
      checkOutput("rel_dtack_r2", {7'd0, bus.DTACK}, 8'h00);
      waitEdges(1);
      checkOutput("rel_dtack_r3", {7'd0, bus.DTACK}, 8'h01);
      checkOutput("rel_dout_z", isZ(data_out === 8'bz), 8'h01);

      // No pending interrupt: IACK low for 20 cycles gets no response
      bus.INT       = 1'b1;
      bus.IACK      = 1'b0;
      dtack_dropped = 1'b0;
      dout_driven   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         waitEdges(1);
         if (bus.DTACK !== 1'b1) dtack_dropped = 1'b1;
         if (data_out !== 8'bz) dout_driven = 1'b1;
      end
      checkOutput("nopend_dtack_held", {7'd0, dtack_dropped}, 8'h00);
      checkOutput("nopend_dout_z", {7'd0, dout_driven}, 8'h00);
      bus.INT = 1'b0;
      waitEdges(1);
      checkOutput("late_int_edge1", {7'd0, bus.DTACK}, 8'h01);
      waitEdges(1);
      checkOutput("late_int_edge2", {7'd0, bus.DTACK}, 8'h00);
      checkOutput("late_int_vector", data_out, 8'h40);

      // IVR write during DRIVE leaves the latched vector alone
      applyStimulus(1'b1, 1'b0, 8'h55);
      waitEdges(1);
      applyStimulus(1'b1, 1'b1, 8'h00);
      checkOutput("drive_vec_stable", data_out, 8'h40);
      applyStimulus(1'b0, 1'b1, 8'h00);
      bus.IACK = 1'b1;
      waitEdges(3);
      checkOutput("drive_release", {7'd0, bus.DTACK}, 8'h01);
      applyStimulus(1'b1, 1'b1, 8'h00);
      checkOutput("ivr_read_55", data_out, 8'h55);
      applyStimulus(1'b0, 1'b1, 8'h00);
      bus.IACK = 1'b0;
      waitEdges(4);
      checkOutput("ack2_dtack", {7'd0, bus.DTACK}, 8'h00);
      checkOutput("ack2_vector", data_out, 8'h55);

      // Reset mid-DRIVE releases the bus without a clock edge
      reset   = 1'b1;
      bus.INT = 1'b1;
      #1;
      checkOutput("midrst_dtack", {7'd0, bus.DTACK}, 8'h01);
      checkOutput("midrst_dout_z", isZ(data_out === 8'bz), 8'h01);
      @(negedge clk);
      reset = 1'b0;
      waitEdges(1);
      applyStimulus(1'b1, 1'b1, 8'h00);
      checkOutput("midrst_ivr", data_out, 8'h0F);
      applyStimulus(1'b0, 1'b1, 8'h00);
      waitEdges(5);
      checkOutput("midrst_no_retrig", {7'd0, bus.DTACK}, 8'h01);
      bus.INT = 1'b0;
      waitEdges(1);
      checkOutput("midrst_int_edge1", {7'd0, bus.DTACK}, 8'h01);
      waitEdges(1);
      checkOutput("midrst_int_edge2", {7'd0, bus.DTACK}, 8'h00);
      checkOutput("midrst_vector", data_out, 8'h0F);
      bus.IACK = 1'b1;
      bus.INT  = 1'b1;
      waitEdges(3);
      checkOutput("midrst_release", {7'd0, bus.DTACK}, 8'h01);

      // DTACK_DELAY=3: interrupt withdrawn during WAIT never produces DTACK
      bus3.INT  = 1'b0;
      bus3.IACK = 1'b0;
      waitEdges(4);
      checkOutput("d3_wait_dtack", {7'd0, bus3.DTACK}, 8'h01);
      bus3.INT      = 1'b1;
      dtack_dropped = 1'b0;
      dout_driven   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         waitEdges(1);
         if (bus3.DTACK !== 1'b1) dtack_dropped = 1'b1;
         if (data_out3 !== 8'bz) dout_driven = 1'b1;
      end
      checkOutput("d3_cleared_no_dtack", {7'd0, dtack_dropped}, 8'h00);
      checkOutput("d3_cleared_dout_z", {7'd0, dout_driven}, 8'h00);
      // Back in IDLE: a fresh request needs 1+3 edges
      bus3.INT = 1'b0;
      waitEdges(3);
      checkOutput("d3_retrig_edge3", {7'd0, bus3.DTACK}, 8'h01);
      waitEdges(1);
      checkOutput("d3_retrig_edge4", {7'd0, bus3.DTACK}, 8'h00);
      checkOutput("d3_vector", data_out3, 8'h0F);
      bus3.IACK = 1'b1;
      bus3.INT  = 1'b1;
      waitEdges(3);
      checkOutput("d3_release", {7'd0, bus3.DTACK}, 8'h01);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/iack_ivr_responder.md
Name: iack_ivr_responder

Overview:
Bus-side responder to the interrupt request produced by the ISR/IMR block of the MC68681 DUART core.
- Holds the Interrupt Vector Register (IVR), readable and writable through the register interface.
- While INT is asserted, answers a CPU interrupt-acknowledge cycle (IACK low) by driving the latched vector onto the data bus and asserting DTACK.
- Releases the bus when IACK negates.

Parameters:
- SYNC_STAGES, 2: flop stages in the IACK synchroniser; legal range ≥2.
- DTACK_DELAY, 1: clk cycles spent in WAIT before DRIVE; legal range 0..15.
- IVR_RESET, 8'h0F: IVR value after reset (uninitialised vector).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  IVR register selected.
- rw  in  1  1 = read, 0 = write.
- data  in  8  write data.
- data_out  out  8  read/vector data; 8'bz when not driving.
- INT  in  1  active-low interrupt request from the ISR/IMR block.
- IACK  in  1  active-low interrupt acknowledge from the CPU; asynchronous to clk.
- DTACK  out  1  active-low data-transfer acknowledge for the IACK cycle.

Behaviour:
- **Clock and reset (already decided):** one clock, clk. reset is asynchronous and active-high. While reset is high:
  - IVR = IVR_RESET, state = IDLE, counter = 0, vector latch = IVR_RESET.
  - Synchroniser flops = 1, DTACK = 1, data_out = 8'bz.
- **IVR access:**
  - cs=1, rw=0: IVR <= data on the clk edge.
  - cs=1, rw=1, state ≠ DRIVE: data_out = IVR (combinational).
  - In DRIVE the vector output has priority and register reads are suppressed.
- **Synchroniser:** IACK passes through SYNC_STAGES flops to give iack_s. The flops reset to 1.
- **FSM states:** IDLE, WAIT, DRIVE.
  - IDLE, iack_s=0 and INT=0: go to WAIT. Load the counter with DTACK_DELAY and latch the vector from the pre-edge IVR value. If DTACK_DELAY=0, go directly to DRIVE.
  - IDLE, iack_s=0 and INT=1 (no pending interrupt): stay in IDLE, no response. The bus is left for external bus-error/spurious handling. Re-evaluated every cycle.
  - WAIT, iack_s=1: go to IDLE (aborted cycle).
  - WAIT, INT=1 (interrupt cleared): go to IDLE, no DTACK.
  - WAIT, otherwise: if counter=1, go to DRIVE; else counter-1.
  - DRIVE: data_out = vector latch; DTACK = 0 (registered, asserted on the entry edge). INT changes are ignored.
  - DRIVE, iack_s=1: go to IDLE. DTACK = 1 and data_out = 8'bz on that same edge.
- **Latency** (defaults, IACK falls just before edge E1): iack_s low after E2, WAIT at E3, DRIVE and DTACK=0 at E4. General formula: edge SYNC_STAGES+1+DTACK_DELAY.
- **Release:** IACK rises before edge R1; DTACK high after edge R(SYNC_STAGES+1).
- **Vector stability:** an IVR write during WAIT or DRIVE updates IVR but never the latch. The new value applies from the next acknowledge.
- **Back-to-back acknowledges:** a new acknowledge requires a return to IDLE, i.e. iack_s observed high for at least one cycle.
- **Reset mid-operation:** DTACK and data_out release immediately (asynchronously), IVR returns to IVR_RESET, state = IDLE.
- **Counter:** 4 bits. No wrap is possible because the load value is ≤15 and the counter stops at 1.

Decomposition:
- Shared package mc68681_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, DRIVE=2'd2; 2'd3 decodes to IDLE on the next edge);
  - IVR_RESET default 8'h0F;
  - the IVR register offset (4'hC), for use by the top-level register decoder.
- One sub-module, sync_ff: parameterised-depth synchroniser with asynchronous reset to 1. It is reused later for the CTS/IP input pins.

Test Plan:
- **Reset:** assert reset → DTACK=1, data_out=8'bz. cs=1, rw=1 after reset → data_out=8'h0F.
- **IVR write/read:** write 8'h40 (cs=1, rw=0) → next read returns 8'h40; data_out=8'bz when cs=0.
- **Basic acknowledge:** INT=0, IACK falls before E1 (defaults) → DTACK=0 and data_out=8'h40 after E4. IACK rises before R1 → DTACK=1 and data_out=z after R3.
- **No pending interrupt:** INT=1, IACK held low for 20 cycles → DTACK stays 1, data_out stays z. Then INT falls → DTACK=0 SYNC_STAGES+DTACK_DELAY... i.e. 1+DTACK_DELAY edges later (2 edges with defaults).
- **Write during DRIVE / interrupt cleared in WAIT:**
  - IVR write 8'h55 during DRIVE → data_out stays 8'h40; the next acknowledge drives 8'h55.
  - With DTACK_DELAY=3, INT rises during WAIT → DTACK never asserts and state returns to IDLE.
- **Reset mid-DRIVE:** reset high while DTACK=0 → DTACK=1 and data_out=z with no clk edge required. After release, IVR=8'h0F and IACK still low re-triggers only once INT=0.
